// File: rtl/matmul_pkg.sv
// Shared types and default sizes for the 10x10 matrix-multiply sequencer.
package matmul_pkg;

  localparam int unsigned ADDR_WIDTH         = 4;
  localparam int unsigned N_DEFAULT          = 10;
  localparam int unsigned DATA_WIDTH_DEFAULT = 8;
  localparam int unsigned ACC_WIDTH_DEFAULT  = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/matmul_ctrl_10x10_if.sv
// Memory-side bus of the sequencer: A/B read ports and the C write port.
interface matmul_ctrl_10x10_if
  import matmul_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEFAULT
);

  logic                  a_en_ReadMat;
  logic [ADDR_WIDTH-1:0] a_rowAddr;
  logic [ADDR_WIDTH-1:0] a_colAddr;
  logic [DATA_WIDTH-1:0] a_readData;

  logic                  b_en_ReadMat;
  logic [ADDR_WIDTH-1:0] b_rowAddr;
  logic [ADDR_WIDTH-1:0] b_colAddr;
  logic [DATA_WIDTH-1:0] b_readData;

  logic                  c_en_WriteMat;
  logic [ADDR_WIDTH-1:0] c_rowAddr;
  logic [ADDR_WIDTH-1:0] c_colAddr;
  logic [ACC_WIDTH-1:0]  c_writeData;

  modport master (
    output a_en_ReadMat, a_rowAddr, a_colAddr,
    input  a_readData,
    output b_en_ReadMat, b_rowAddr, b_colAddr,
    input  b_readData,
    output c_en_WriteMat, c_rowAddr, c_colAddr, c_writeData
  );

  modport slave (
    input  a_en_ReadMat, a_rowAddr, a_colAddr,
    output a_readData,
    input  b_en_ReadMat, b_rowAddr, b_colAddr,
    output b_readData,
    input  c_en_WriteMat, c_rowAddr, c_colAddr, c_writeData
  );

endinterface

// File: rtl/matmul_ctrl_10x10_mac_unit.sv
// Unsigned multiply-accumulate: registered accumulator plus a combinational
// running sum so the final product can be folded in without an extra cycle.
module mac_unit #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  acc_en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  sum_c
);

  localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

  logic [ACC_WIDTH-1:0]  acc;
  logic [PROD_WIDTH-1:0] prod;

  assign prod  = PROD_WIDTH'(a) * PROD_WIDTH'(b);
  assign sum_c = acc + ACC_WIDTH'(prod);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (acc_en) begin
      acc <= sum_c;
    end
  end

endmodule

// File: rtl/matmul_ctrl_10x10.sv
// C = A x B sequencer: walks (i,j) row-major, streams k through A/B reads,
// and writes each accumulated C entry in a single WRITE cycle.
module matmul_ctrl_10x10
  import matmul_pkg::*;
#(
  parameter int unsigned N          = N_DEFAULT,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  matmul_ctrl_10x10_if.master mem
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(N - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] i, j, k;
  logic [ADDR_WIDTH-1:0] i_nxt, j_nxt, k_nxt;
  logic                  rd_en, c_en;
  logic                  mac_clr, mac_acc;
  logic [ACC_WIDTH-1:0]  sum_c;

  // Next-state, counter advance and accumulator control
  always_comb begin
    state_nxt = state;
    i_nxt     = i;
    j_nxt     = j;
    k_nxt     = k;
    mac_clr   = 1'b0;
    mac_acc   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          i_nxt     = '0;
          j_nxt     = '0;
          k_nxt     = '0;
        end
      end
      RUN: begin
        // Data returned this cycle belongs to k-1; k=0 starts a fresh sum
        mac_clr = (k == '0);
        mac_acc = (k != '0);
        if (k == LAST) begin
          state_nxt = WRITE;
        end else begin
          k_nxt = k + ONE;
        end
      end
      WRITE: begin
        k_nxt     = '0;
        state_nxt = RUN;
        if (j == LAST) begin
          j_nxt = '0;
          if (i == LAST) begin
            i_nxt     = '0;
            state_nxt = DONE;
          end else begin
            i_nxt = i + ONE;
          end
        end else begin
          j_nxt = j + ONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, counters and registered strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      rd_en <= 1'b0;
      c_en  <= 1'b0;
    end else begin
      state <= state_nxt;
      i     <= i_nxt;
      j     <= j_nxt;
      k     <= k_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state_nxt == DONE);
      rd_en <= (state_nxt == RUN);
      c_en  <= (state_nxt == WRITE);
    end
  end

  mac_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr    (mac_clr),
    .acc_en (mac_acc),
    .a      (mem.a_readData),
    .b      (mem.b_readData),
    .sum_c  (sum_c)
  );

  assign mem.a_en_ReadMat  = rd_en;
  assign mem.a_rowAddr     = i;
  assign mem.a_colAddr     = k;
  assign mem.b_en_ReadMat  = rd_en;
  assign mem.b_rowAddr     = k;
  assign mem.b_colAddr     = j;
  assign mem.c_en_WriteMat = c_en;
  assign mem.c_rowAddr     = i;
  assign mem.c_colAddr     = j;
  // Held at zero outside WRITE so stale read data never shows on the bus
  assign mem.c_writeData   = c_en ? sum_c : '0;

endmodule

// File: tb/tb_matmul_ctrl_10x10.sv
// Bench for matmul_ctrl_10x10: behavioural A/B/C memories, scoreboard of
// expected C writes, table of data patterns plus start/reset corner sequences.
module tb_matmul_ctrl_10x10;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;

  matmul_ctrl_10x10_if #(.DATA_WIDTH(8), .ACC_WIDTH(20)) mem ();

  matmul_ctrl_10x10 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .mem   (mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         r;
    int         c;
    logic [19:0] d;
    int         cyc;
  } wr_t;

  typedef struct {
    int a_mode;
    int b_mode;
    int exp_u;
  } vec_t;

  logic [7:0]  A  [10][10];
  logic [7:0]  B  [10][10];
  logic [19:0] Cm [10][10];
  bit          clr_c = 1'b0;
  wr_t         sb[$];
  vec_t        vt[3];
  int          n_cmp = 0;
  int          n_err = 0;

  // Memory models: 1-cycle registered reads, C captured on write enable
  always @(posedge clk) begin
    if (mem.a_en_ReadMat) mem.a_readData <= A[mem.a_rowAddr][mem.a_colAddr];
    if (mem.b_en_ReadMat) mem.b_readData <= B[mem.b_rowAddr][mem.b_colAddr];
    if (clr_c) begin
      for (int r = 0; r < 10; r++)
        for (int c = 0; c < 10; c++) Cm[r][c] <= 20'hFFFFF;
    end else if (mem.c_en_WriteMat) begin
      Cm[mem.c_rowAddr][mem.c_colAddr] <= mem.c_writeData;
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [19:0] ref_c(input int r, input int c);
    longint s = 0;
    for (int k = 0; k < 10; k++) s += longint'(A[r][k]) * longint'(B[k][c]);
    return 20'(s);
  endfunction

  // a_mode: 0 identity, 1 all 0xFF, 2 all 1, 3 random; b_mode: 0/3 random, 1 0xFF, 2 row index
  task automatic load(input int a_mode, input int b_mode);
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < 10; c++) begin
        case (a_mode)
          0:       A[r][c] = (r == c) ? 8'd1 : 8'd0;
          1:       A[r][c] = 8'hFF;
          2:       A[r][c] = 8'd1;
          default: A[r][c] = 8'($urandom_range(255));
        endcase
        case (b_mode)
          1:       B[r][c] = 8'hFF;
          2:       B[r][c] = 8'(r);
          default: B[r][c] = 8'($urandom_range(255));
        endcase
      end
    end
  endtask

  // mode 0: entries below 'upto' match the model, the rest untouched; 1: C == B; 2: all == exp_u
  function automatic int c_mismatches(input int mode, input int exp_u, input int upto);
    int n = 0;
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < 10; c++) begin
        case (mode)
          0:       if ((r * 10 + c) < upto) n += int'(Cm[r][c] !== ref_c(r, c));
                   else n += int'(Cm[r][c] !== 20'hFFFFF);
          1:       n += int'(Cm[r][c] !== 20'(B[r][c]));
          default: n += int'(Cm[r][c] !== 20'(exp_u));
        endcase
      end
    end
    return n;
  endfunction

  // One multiply: start, extra start pulses at x1/x2, optional reset at rst_at,
  // monitored for 'limit' cycles (cycle 1 is the one after the accepting edge)
  task automatic run_op(input int x1, input int x2, input int rst_at, input int limit);
    int  n_wr = 0;
    int  n_done = 0;
    int  done_cyc = -1;
    int  busy_first = -1;
    int  busy_last = -1;
    int  proto = 0;
    wr_t e;
    clr_c = 1'b1;
    @(negedge clk);
    clr_c = 1'b0;
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++)
        sb.push_back('{r, c, ref_c(r, c), 11 + 11 * (r * 10 + c)});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      if (mem.a_en_ReadMat !== mem.b_en_ReadMat) proto++;
      if (mem.a_en_ReadMat && mem.c_en_WriteMat) proto++;
      if (!busy && (mem.a_en_ReadMat || mem.b_en_ReadMat)) proto++;
      if (busy) begin
        if (busy_first < 0) busy_first = cyc;
        busy_last = cyc;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (mem.c_en_WriteMat) begin
        n_wr++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL c_write: unexpected write (%0d,%0d)=%0d at cycle %0d",
                   mem.c_rowAddr, mem.c_colAddr, mem.c_writeData, cyc);
        end else begin
          e = sb.pop_front();
          if (mem.c_rowAddr !== 4'(e.r) || mem.c_colAddr !== 4'(e.c) ||
              mem.c_writeData !== e.d || cyc != e.cyc) begin
            n_err++;
            $display("FAIL c_write: got (%0d,%0d)=%0d at cycle %0d, expected (%0d,%0d)=%0d at cycle %0d",
                     mem.c_rowAddr, mem.c_colAddr, mem.c_writeData, cyc, e.r, e.c, e.d, e.cyc);
          end
        end
      end
      if (rst_at > 0 && cyc == rst_at + 1) begin
        chk("rst_drop", {busy, done, mem.a_en_ReadMat, mem.b_en_ReadMat, mem.c_en_WriteMat}, 0);
        chk("writes_before_rst", n_wr, (rst_at - 11) / 11 + 1);
        sb.delete();
      end
      start = (cyc == x1 || cyc == x2);
      rst   = (rst_at > 0 && cyc == rst_at);
      @(negedge clk);
    end
    start = 1'b0;
    rst   = 1'b0;
    chk("protocol", proto, 0);
    if (rst_at > 0) begin
      chk("done_after_rst", n_done, 0);
      chk("writes_total_rst", n_wr, (rst_at - 11) / 11 + 1);
    end else begin
      chk("writes", n_wr, 100);
      chk("done_pulses", n_done, 1);
      chk("done_cycle", done_cyc, 1101);
      chk("busy_first", busy_first, 1);
      chk("busy_last", busy_last, 1101);
      chk("sb_left", sb.size(), 0);
    end
  endtask

  initial begin
    vt[0] = '{0, 0, -1};
    vt[1] = '{1, 1, 650250};
    vt[2] = '{2, 2, 45};

    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk("rst_strobes", {busy, done, mem.a_en_ReadMat, mem.b_en_ReadMat, mem.c_en_WriteMat}, 0);
    chk("rst_addr", {mem.a_rowAddr, mem.a_colAddr, mem.b_rowAddr, mem.b_colAddr,
                     mem.c_rowAddr, mem.c_colAddr}, 0);
    chk("rst_wdata", mem.c_writeData, 0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle_after_rst_start", {busy, mem.a_en_ReadMat}, 0);

    for (int v = 0; v < 3; v++) begin
      load(vt[v].a_mode, vt[v].b_mode);
      run_op(-1, -1, 0, 1105);
      chk("c_vs_model", c_mismatches(0, 0, 100), 0);
      if (vt[v].exp_u < 0) chk("c_eq_b", c_mismatches(1, 0, 0), 0);
      else chk("c_uniform", c_mismatches(2, vt[v].exp_u, 0), 0);
    end

    load(3, 3);
    run_op(5, 500, 0, 1105);
    chk("c_vs_model_restart", c_mismatches(0, 0, 100), 0);

    load(3, 3);
    run_op(-1, -1, 300, 400);
    chk("c_partial_kept", c_mismatches(0, 0, 27), 0);

    load(3, 0);
    run_op(-1, -1, 0, 1105);
    chk("c_vs_model_after_rst", c_mismatches(0, 0, 100), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
